// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-client memory bus arbiter:
// default bus widths and the arbiter state encoding.
package bus_arbiter_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

endpackage

// File: rtl/arb_req_slot.sv
// One client's request slot: pending flag, latched request fields and the
// held read-data register returned to that client.
module arb_req_slot
   import bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   input  logic              we,
   input  logic              active,
   input  logic              grant,
   input  logic              done,
   input  logic [DATA_W-1:0] m_q,
   output logic              eff_pending,
   output logic [ADDR_W-1:0] eff_addr,
   output logic [DATA_W-1:0] eff_data,
   output logic              eff_we,
   output logic [DATA_W-1:0] q,
   output logic              ready
);

   logic              pending_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] data_reg;
   logic              we_reg;
   logic [DATA_W-1:0] q_reg;
   logic              accept;

   // A start is only taken when this client has nothing pending or in flight;
   // a freshly accepted start is visible to the grant logic in the same cycle.
   assign accept      = start && !pending_reg && !active;
   assign eff_pending = pending_reg || accept;
   assign eff_addr    = accept ? addr : addr_reg;
   assign eff_data    = accept ? data : data_reg;
   assign eff_we      = accept ? we   : we_reg;
   assign ready       = !(pending_reg || active);
   assign q           = done ? m_q : q_reg;

   // Latch accepted requests, track pending until granted, hold returned data.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_reg <= 1'b0;
         addr_reg    <= '0;
         data_reg    <= '0;
         we_reg      <= 1'b0;
         q_reg       <= '0;
      end else begin
         if (accept) begin
            addr_reg <= addr;
            data_reg <= data;
            we_reg   <= we;
         end
         pending_reg <= eff_pending && !grant;
         if (done) begin
            q_reg <= m_q;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Two-client memory bus arbiter: serialises instruction and data requests
// onto a single memory bus, data port having fixed priority.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_we,
   input  logic              i_start,
   output logic [DATA_W-1:0] i_q,
   output logic              i_done,
   output logic              i_ready,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_data,
   input  logic              d_we,
   input  logic              d_start,
   output logic [DATA_W-1:0] d_q,
   output logic              d_done,
   output logic              d_ready,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_data,
   output logic              m_we,
   output logic              m_start,
   input  logic [DATA_W-1:0] m_q,
   input  logic              m_done,
   input  logic              m_ready
);

   arb_state_t        state;
   arb_state_t        next_state;
   logic              grant_i;
   logic              grant_d;
   logic              active_i;
   logic              active_d;
   logic              pend_i;
   logic              pend_d;
   logic [ADDR_W-1:0] req_addr_i;
   logic [ADDR_W-1:0] req_addr_d;
   logic [DATA_W-1:0] req_data_i;
   logic [DATA_W-1:0] req_data_d;
   logic              req_we_i;
   logic              req_we_d;

   assign active_i = (state == BUSY_I);
   assign active_d = (state == BUSY_D);

   arb_req_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_slot_i (
      .clk         (clk),
      .reset       (reset),
      .start       (i_start),
      .addr        (i_addr),
      .data        (i_data),
      .we          (i_we),
      .active      (active_i),
      .grant       (grant_i),
      .done        (i_done),
      .m_q         (m_q),
      .eff_pending (pend_i),
      .eff_addr    (req_addr_i),
      .eff_data    (req_data_i),
      .eff_we      (req_we_i),
      .q           (i_q),
      .ready       (i_ready)
   );

   arb_req_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_slot_d (
      .clk         (clk),
      .reset       (reset),
      .start       (d_start),
      .addr        (d_addr),
      .data        (d_data),
      .we          (d_we),
      .active      (active_d),
      .grant       (grant_d),
      .done        (d_done),
      .m_q         (m_q),
      .eff_pending (pend_d),
      .eff_addr    (req_addr_d),
      .eff_data    (req_data_d),
      .eff_we      (req_we_d),
      .q           (d_q),
      .ready       (d_ready)
   );

   // Grant decision in IDLE and completion routing to the owning client;
   // a done arriving during reset is swallowed so abandoned work stays silent.
   always_comb begin
      next_state = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      i_done     = 1'b0;
      d_done     = 1'b0;
      case (state)
         IDLE: begin
            if (m_ready && (pend_d || pend_i)) begin
               if (pend_d) begin
                  grant_d    = 1'b1;
                  next_state = BUSY_D;
               end else begin
                  grant_i    = 1'b1;
                  next_state = BUSY_I;
               end
            end
         end
         BUSY_I: begin
            if (m_done) begin
               i_done     = 1'b1;
               next_state = IDLE;
            end
         end
         BUSY_D: begin
            if (m_done) begin
               d_done     = 1'b1;
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      if (reset) begin
         i_done = 1'b0;
         d_done = 1'b0;
      end
   end

   // State register plus the registered bus request, loaded from the winner.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         m_start <= 1'b0;
         m_addr  <= '0;
         m_data  <= '0;
         m_we    <= 1'b0;
      end else begin
         state   <= next_state;
         m_start <= grant_i || grant_d;
         if (grant_d) begin
            m_addr <= req_addr_d;
            m_data <= req_data_d;
            m_we   <= req_we_d;
         end else if (grant_i) begin
            m_addr <= req_addr_i;
            m_data <= req_data_i;
            m_we   <= req_we_i;
         end
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_bus_arbiter;

   logic        clk;
   logic        reset;
   logic [31:0] i_addr, i_data, i_q;
   logic        i_we, i_start, i_done, i_ready;
   logic [31:0] d_addr, d_data, d_q;
   logic        d_we, d_start, d_done, d_ready;
   logic [31:0] m_addr, m_data, m_q;
   logic        m_we, m_start, m_done, m_ready;

   int checksTotal;
   int checksPassed;

   bus_arbiter dut (
      .clk     (clk),
      .reset   (reset),
      .i_addr  (i_addr),
      .i_data  (i_data),
      .i_we    (i_we),
      .i_start (i_start),
      .i_q     (i_q),
      .i_done  (i_done),
      .i_ready (i_ready),
      .d_addr  (d_addr),
      .d_data  (d_data),
      .d_we    (d_we),
      .d_start (d_start),
      .d_q     (d_q),
      .d_done  (d_done),
      .d_ready (d_ready),
      .m_addr  (m_addr),
      .m_data  (m_data),
      .m_we    (m_we),
      .m_start (m_start),
      .m_q     (m_q),
      .m_done  (m_done),
      .m_ready (m_ready)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checksTotal++;
      if (act === exp) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: each client owns a request record and a pending bit,
   // the bus has at most one owner (0 none, 1 instruction, 2 data).
   logic        modelValid;
   logic        mPend [2];
   logic [31:0] mAddr [2];
   logic [31:0] mData [2];
   logic        mWe   [2];
   logic [31:0] qHold [2];
   int          mOwner;
   logic        eStart, eWe;
   logic [31:0] eAddr, eData;
   logic        accI, accD, expIDone, expDDone;
   int          pick;

   initial modelValid = 1'b0;

   // Single compare process: check every cycle at the falling edge, then
   // advance the model by the rules for the coming rising edge.
   always @(negedge clk) begin
      if (modelValid) begin
         accI     = i_start && !mPend[0] && (mOwner != 1);
         accD     = d_start && !mPend[1] && (mOwner != 2);
         expIDone = !reset && m_done && (mOwner == 1);
         expDDone = !reset && m_done && (mOwner == 2);
         checkOutput("m_start", m_start, eStart);
         checkOutput("m_addr", m_addr, eAddr);
         checkOutput("m_data", m_data, eData);
         checkOutput("m_we", m_we, eWe);
         checkOutput("i_done", i_done, expIDone);
         checkOutput("d_done", d_done, expDDone);
         checkOutput("i_q", i_q, expIDone ? m_q : qHold[0]);
         checkOutput("d_q", d_q, expDDone ? m_q : qHold[1]);
         checkOutput("i_ready", i_ready, !(mPend[0] || mOwner == 1));
         checkOutput("d_ready", d_ready, !(mPend[1] || mOwner == 2));
      end
      if (reset) begin
         for (int k = 0; k < 2; k++) begin
            mPend[k] = 1'b0;
            mAddr[k] = '0;
            mData[k] = '0;
            mWe[k]   = 1'b0;
            qHold[k] = '0;
         end
         mOwner     = 0;
         eStart     = 1'b0;
         eAddr      = '0;
         eData      = '0;
         eWe        = 1'b0;
         modelValid = 1'b1;
      end else if (modelValid) begin
         if (accI) begin
            mPend[0] = 1'b1;
            mAddr[0] = i_addr;
            mData[0] = i_data;
            mWe[0]   = i_we;
         end
         if (accD) begin
            mPend[1] = 1'b1;
            mAddr[1] = d_addr;
            mData[1] = d_data;
            mWe[1]   = d_we;
         end
         eStart = 1'b0;
         if (expIDone) begin
            qHold[0] = m_q;
            mOwner   = 0;
         end else if (expDDone) begin
            qHold[1] = m_q;
            mOwner   = 0;
         end else if (mOwner == 0 && m_ready && (mPend[0] || mPend[1])) begin
            pick        = mPend[1] ? 1 : 0;
            eAddr       = mAddr[pick];
            eData       = mData[pick];
            eWe         = mWe[pick];
            eStart      = 1'b1;
            mPend[pick] = 1'b0;
            mOwner      = pick + 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int cycles);
      int memLeft;
      memLeft = 0;
      for (int c = 0; c < cycles; c++) begin
         step();
         m_done = 1'b0;
         m_q    = $urandom;
         if ($urandom_range(0, 199) == 0) begin
            reset   = 1'b1;
            memLeft = 0;
            i_start = 1'b0;
            d_start = 1'b0;
            m_ready = $urandom_range(0, 1) == 1;
         end else begin
            reset = 1'b0;
            if (m_start) begin
               memLeft = $urandom_range(1, 4);
            end else if (memLeft > 0) begin
               memLeft--;
               if (memLeft == 0) m_done = 1'b1;
            end else if ($urandom_range(0, 29) == 0) begin
               m_done = 1'b1;
            end
            m_ready = (memLeft == 0) && ($urandom_range(0, 3) != 0);
            i_start = i_ready && ($urandom_range(0, 3) == 0);
            d_start = d_ready && ($urandom_range(0, 3) == 0);
            i_addr  = $urandom;
            i_data  = $urandom;
            i_we    = ($urandom_range(0, 7) == 0);
            d_addr  = $urandom;
            d_data  = $urandom;
            d_we    = $urandom_range(0, 1) == 1;
         end
      end
      step();
      reset   = 1'b0;
      i_start = 1'b0;
      d_start = 1'b0;
      m_done  = 1'b0;
   endtask

   // Directed scenarios with hand-computed values, then random traffic.
   initial begin
      checksTotal  = 0;
      checksPassed = 0;
      reset   = 1'b1;
      i_addr  = '0; i_data = '0; i_we = 1'b0; i_start = 1'b0;
      d_addr  = '0; d_data = '0; d_we = 1'b0; d_start = 1'b0;
      m_q     = '0; m_done = 1'b0; m_ready = 1'b0;
      step(); step();
      reset = 1'b0;
      #2 checkOutput("reset_m_start", m_start, 0);
      checkOutput("reset_m_addr", m_addr, 0);
      checkOutput("reset_i_ready", i_ready, 1);
      checkOutput("reset_d_ready", d_ready, 1);
      checkOutput("reset_i_q", i_q, 0);
      step();

      // Single instruction fetch.
      step(); i_start = 1'b1; i_addr = 32'h100; m_ready = 1'b1;
      #2 checkOutput("t1_i_ready_before", i_ready, 1);
      step(); i_start = 1'b0; m_ready = 1'b0;
      #2 checkOutput("t1_m_start", m_start, 1);
      checkOutput("t1_m_addr", m_addr, 32'h100);
      checkOutput("t1_m_we", m_we, 0);
      checkOutput("t1_i_ready_busy", i_ready, 0);
      step();
      #2 checkOutput("t1_m_start_pulse", m_start, 0);
      step(); m_done = 1'b1; m_q = 32'hDEADBEEF;
      #2 checkOutput("t1_i_done", i_done, 1);
      checkOutput("t1_i_q_comb", i_q, 32'hDEADBEEF);
      checkOutput("t1_d_done", d_done, 0);
      step(); m_done = 1'b0; m_q = 32'h0;
      #2 checkOutput("t1_i_q_held", i_q, 32'hDEADBEEF);
      checkOutput("t1_i_done_low", i_done, 0);
      checkOutput("t1_i_ready_after", i_ready, 1);

      // Simultaneous starts: data first.
      step(); i_start = 1'b1; i_addr = 32'h200;
      d_start = 1'b1; d_addr = 32'h3000; d_we = 1'b1; d_data = 32'h55; m_ready = 1'b1;
      step(); i_start = 1'b0; d_start = 1'b0; d_we = 1'b0; d_data = '0; m_ready = 1'b0;
      #2 checkOutput("t2_m_start_d", m_start, 1);
      checkOutput("t2_m_addr_d", m_addr, 32'h3000);
      checkOutput("t2_m_we_d", m_we, 1);
      checkOutput("t2_m_data_d", m_data, 32'h55);
      step(); m_done = 1'b1; m_q = 32'h11;
      #2 checkOutput("t2_d_done", d_done, 1);
      checkOutput("t2_i_done_not", i_done, 0);
      checkOutput("t2_d_q", d_q, 32'h11);
      step(); m_done = 1'b0; m_ready = 1'b1;
      #2 checkOutput("t2_gap", m_start, 0);
      step(); m_ready = 1'b0;
      #2 checkOutput("t2_m_start_i", m_start, 1);
      checkOutput("t2_m_addr_i", m_addr, 32'h200);
      checkOutput("t2_m_we_i", m_we, 0);
      step(); m_done = 1'b1; m_q = 32'h22;
      #2 checkOutput("t2_i_done", i_done, 1);
      checkOutput("t2_i_q", i_q, 32'h22);
      step(); m_done = 1'b0;

      // Spurious done while idle.
      step(); m_done = 1'b1; m_q = 32'h1234;
      #2 checkOutput("t6_i_done", i_done, 0);
      checkOutput("t6_d_done", d_done, 0);
      checkOutput("t6_i_q", i_q, 32'h22);
      checkOutput("t6_d_q", d_q, 32'h11);
      step(); m_done = 1'b0;

      // Data start while instruction in flight.
      step(); i_start = 1'b1; i_addr = 32'h600; m_ready = 1'b1;
      step(); i_start = 1'b0; m_ready = 1'b0; d_start = 1'b1; d_addr = 32'h700;
      #2 checkOutput("t3_m_start_i", m_start, 1);
      step(); d_start = 1'b0;
      #2 checkOutput("t3_d_ready_low", d_ready, 0);
      checkOutput("t3_no_start", m_start, 0);
      step(); m_done = 1'b1; m_q = 32'h5;
      #2 checkOutput("t3_i_done", i_done, 1);
      checkOutput("t3_d_done_not", d_done, 0);
      step(); m_done = 1'b0; m_ready = 1'b1;
      step(); m_ready = 1'b0;
      #2 checkOutput("t3_m_start_d", m_start, 1);
      checkOutput("t3_m_addr_d", m_addr, 32'h700);
      step(); m_done = 1'b1; m_q = 32'h6;
      #2 checkOutput("t3_d_done", d_done, 1);
      step(); m_done = 1'b0;

      // Reset while data transaction in flight.
      step(); d_start = 1'b1; d_addr = 32'h4000; m_ready = 1'b1;
      step(); d_start = 1'b0; m_ready = 1'b0;
      #2 checkOutput("t4_m_start", m_start, 1);
      step(); reset = 1'b1;
      step(); reset = 1'b0;
      #2 checkOutput("t4_d_ready", d_ready, 1);
      checkOutput("t4_m_start_cleared", m_start, 0);
      step(); m_done = 1'b1; m_q = 32'h99;
      #2 checkOutput("t4_d_done", d_done, 0);
      checkOutput("t4_i_done", i_done, 0);
      checkOutput("t4_d_q", d_q, 32'h0);
      step(); m_done = 1'b0;

      // Memory not ready for several cycles.
      step(); i_start = 1'b1; i_addr = 32'h500; m_ready = 1'b0;
      step(); i_start = 1'b0;
      #2 checkOutput("t5_i_ready", i_ready, 0);
      for (int k = 0; k < 4; k++) begin
         step();
         #2 checkOutput("t5_stall", m_start, 0);
      end
      m_ready = 1'b1;
      step(); m_ready = 1'b0;
      #2 checkOutput("t5_m_start", m_start, 1);
      checkOutput("t5_m_addr", m_addr, 32'h500);
      step(); m_done = 1'b1; m_q = 32'h77;
      #2 checkOutput("t5_i_q", i_q, 32'h77);
      step(); m_done = 1'b0;

      $display("[TB] starting randomized traffic");
      applyStimulus(3000);
      step();
      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
